// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: freeze patterns,
// FSM encodings and the zero word.
package pipe_ctrl_pkg;

  localparam int unsigned StallBus = 6;

  localparam logic [StallBus-1:0] NoStall     = 6'b000000;
  localparam logic [StallBus-1:0] StallFromId = 6'b000111;
  localparam logic [StallBus-1:0] StallFromEx = 6'b001111;

  localparam logic [1:0] CtrlIdle  = 2'd0;
  localparam logic [1:0] CtrlMulti = 2'd1;
  localparam logic [1:0] CtrlFlush = 2'd2;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: per-stage freeze vector,
// multi-cycle EX hold counter and MEM-originated redirect flush.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULTI_CYCLES = 32,
  parameter int unsigned CNT_W        = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                ex_multi_start,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [StallBus-1:0] stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                ex_multi_done,
  output logic                busy
);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [StallBus-1:0] stall_c;
  logic                flush_c;
  logic                done_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CtrlIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = NoStall;
    flush_c = 1'b0;
    done_c  = 1'b0;
    if (flush_req) begin
      // Redirect beats everything, including a pending multi-cycle result.
      flush_c = 1'b1;
      state_d = CtrlFlush;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CtrlIdle: begin
          if (ex_multi_start) begin
            stall_c = StallFromEx;
            cnt_d   = CNT_W'(MULTI_CYCLES - 2);
            state_d = CtrlMulti;
          end else if (stallreq_id) begin
            stall_c = StallFromId;
          end
        end
        CtrlMulti: begin
          if (cnt_q != '0) begin
            stall_c = StallFromEx;
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            done_c  = 1'b1;
            state_d = CtrlIdle;
          end
        end
        // Wrong-path hazard requests are masked for this one cycle.
        CtrlFlush: state_d = CtrlIdle;
        default:   state_d = CtrlIdle;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, regardless of inputs.
  assign stall         = rst ? stall_c : NoStall;
  assign flush         = rst & flush_c;
  assign new_pc        = (rst && flush_req) ? flush_pc : ZeroWord;
  assign ex_multi_done = rst & done_c;
  assign busy          = rst && (state_q == CtrlMulti);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (MULTI_CYCLES=4), plus an
// async-reset / long-op sequence on a MULTI_CYCLES=32 instance.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, ex_multi_start, flush_req;
  logic [31:0] flush_pc;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b, done_a, done_b, busy_a, busy_b;
  logic [31:0] new_pc_a, new_pc_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MULTI_CYCLES(4), .CNT_W(6)) dut_a (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_multi_start(ex_multi_start),
    .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall_a), .flush(flush_a),
    .new_pc(new_pc_a), .ex_multi_done(done_a), .busy(busy_a)
  );

  pipe_ctrl #(.MULTI_CYCLES(32), .CNT_W(6)) dut_b (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_multi_start(ex_multi_start),
    .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall_b), .flush(flush_b),
    .new_pc(new_pc_b), .ex_multi_done(done_b), .busy(busy_b)
  );

  typedef struct {
    logic        sreq;
    logic        start;
    logic        freq;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic s, input logic m, input logic f, input logic [31:0] pc);
    stallreq_id    = s;
    ex_multi_start = m;
    flush_req      = f;
    flush_pc       = pc;
  endtask

  initial begin
    int cycles;
    //            sreq start freq fpc            stall      flush pc             done busy
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h00000180, 6'b000000, 1'b1, 32'h00000180, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h00000200, 6'b000000, 1'b1, 32'h00000200, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h00000300, 6'b000000, 1'b1, 32'h00000300, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 1'b0};

    // Reset held with random inputs: everything must stay quiet.
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_in(1'($urandom), 1'($urandom), 1'b1, $urandom);
      #3;
      chk("rst_stall", 32'(stall_a), 32'h0);
      chk("rst_flush", 32'(flush_a), 32'h0);
      chk("rst_new_pc", new_pc_a, 32'h0);
      chk("rst_done", 32'(done_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      set_in(vecs[i].sreq, vecs[i].start, vecs[i].freq, vecs[i].fpc);
      #3;
      chk($sformatf("v%0d_stall", i), 32'(stall_a), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_flush", i), 32'(flush_a), 32'(vecs[i].e_flush));
      chk($sformatf("v%0d_new_pc", i), new_pc_a, vecs[i].e_pc);
      chk($sformatf("v%0d_done", i), 32'(done_a), 32'(vecs[i].e_done));
      chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(vecs[i].e_busy));
      @(posedge clk); #1;
    end

    // Async reset in the middle of a 32-cycle op, away from any clock edge.
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("b_busy_pre", 32'(busy_b), 32'h1);
    #2;
    set_in(1'b1, 1'b0, 1'b1, 32'hdead_beef);
    rst = 1'b0;
    #1;
    chk("arst_stall", 32'(stall_b), 32'h0);
    chk("arst_busy", 32'(busy_b), 32'h0);
    chk("arst_done", 32'(done_b), 32'h0);
    chk("arst_flush", 32'(flush_b), 32'h0);
    chk("arst_new_pc", new_pc_b, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;

    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    #3;
    chk("b_start_stall", 32'(stall_b), 32'h0000000f);
    cycles = 0;
    while (!done_b && cycles < 40) begin
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      cycles++;
      #3;
      if (!done_b && stall_b !== 6'b001111) begin
        chk("b_hold_stall", 32'(stall_b), 32'h0000000f);
      end
    end
    chk("b_done_cycle", 32'(cycles), 32'd31);
    chk("b_done_stall", 32'(stall_b), 32'h0);
    @(posedge clk); #4;
    chk("b_idle_busy", 32'(busy_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
